// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-initiator memory arbiter:
// FSM state encoding, port identifiers and the round-robin pick.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // With both ports pending the one not served last wins; otherwise the lone requester.
    function automatic port_t rr_pick(input logic pend_i, input logic pend_d, input port_t last);
        if (pend_d && (!pend_i || last == PORT_I))
            return PORT_D;
        return PORT_I;
    endfunction

    function automatic state_t busy_state(input port_t p);
        return (p == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_port.sv
// Per-initiator bookkeeping: re-arm tracking so a start still held after done
// cannot re-trigger, plus the registered read-data and done-pulse outputs.
module mem_arbiter_port
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              complete,
    input  logic [DATA_W-1:0] sdc_q,
    output logic              pending,
    output logic [DATA_W-1:0] q,
    output logic              done
);

    logic              armed_reg;
    logic [DATA_W-1:0] q_reg;
    logic              done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_reg <= 1'b0;
            q_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= complete;
            // Completion disarms even if start was already withdrawn; a low start re-arms next cycle.
            if (complete) begin
                q_reg     <= sdc_q;
                armed_reg <= 1'b0;
            end else if (!start) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign pending = start && armed_reg;
    assign q       = q_reg;
    assign done    = done_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache start/done requests onto
// a single SDRAM-controller bus, one transaction outstanding at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_start,
    output logic [DATA_W-1:0] i_q,
    output logic              i_done,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    input  logic              d_start,
    output logic [DATA_W-1:0] d_q,
    output logic              d_done,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [DATA_W-1:0] sdc_q,
    input  logic              sdc_done
);

    state_t            state_reg;
    port_t             last_reg;
    port_t             grant_port;
    logic [ADDR_W-1:0] sdc_addr_reg;
    logic [DATA_W-1:0] sdc_data_reg;
    logic              sdc_we_reg;
    logic              sdc_start_reg;

    logic [1:0]        start_vec;
    logic [1:0]        pending_vec;
    logic [1:0]        complete_vec;
    logic [1:0]        done_vec;
    logic [DATA_W-1:0] q_vec [2];

    // Bit 0 is the I port, bit 1 the D port.
    assign start_vec    = {d_start, i_start};
    assign complete_vec = {sdc_done && (state_reg == ST_BUSY_D),
                           sdc_done && (state_reg == ST_BUSY_I)};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            mem_arbiter_port #(
                .DATA_W (DATA_W)
            ) u_port (
                .clk      (clk),
                .reset    (reset),
                .start    (start_vec[gi]),
                .complete (complete_vec[gi]),
                .sdc_q    (sdc_q),
                .pending  (pending_vec[gi]),
                .q        (q_vec[gi]),
                .done     (done_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        grant_port = rr_pick(pending_vec[0], pending_vec[1], last_reg);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            last_reg      <= PORT_I;
            sdc_addr_reg  <= '0;
            sdc_data_reg  <= '0;
            sdc_we_reg    <= 1'b0;
            sdc_start_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A stray sdc_done here is deliberately ignored.
                    if (|pending_vec) begin
                        state_reg     <= busy_state(grant_port);
                        last_reg      <= grant_port;
                        sdc_start_reg <= 1'b1;
                        if (grant_port == PORT_D) begin
                            sdc_addr_reg <= d_addr;
                            sdc_data_reg <= d_data;
                            sdc_we_reg   <= d_we;
                        end else begin
                            sdc_addr_reg <= i_addr;
                            sdc_data_reg <= i_data;
                            sdc_we_reg   <= i_we;
                        end
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (sdc_done) begin
                        state_reg     <= ST_IDLE;
                        sdc_start_reg <= 1'b0;
                        sdc_addr_reg  <= '0;
                        sdc_data_reg  <= '0;
                        sdc_we_reg    <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sdc_addr  = sdc_addr_reg;
    assign sdc_data  = sdc_data_reg;
    assign sdc_we    = sdc_we_reg;
    assign sdc_start = sdc_start_reg;
    assign i_q       = q_vec[0];
    assign i_done    = done_vec[0];
    assign d_q       = q_vec[1];
    assign d_done    = done_vec[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural SDRAM controller answers the
// arbiter, and every done pulse is matched against the expected grant queue.
module tb_mem_arbiter;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [31:0] data;
        bit          we;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_addr, i_data, d_addr, d_data;
    logic        i_we, i_start, d_we, d_start;
    logic [31:0] i_q, d_q;
    logic        i_done, d_done;
    logic [31:0] sdc_addr, sdc_data, sdc_q;
    logic        sdc_we, sdc_start, sdc_done;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   gap = 0;
    int   done_cyc = 0;
    int   i_cnt = 0;
    int   d_cnt = 0;
    int   spur_req = 0;
    int   spur_done = 0;
    logic [31:0] mi = '0;
    logic [31:0] md = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .i_we      (i_we),
        .i_start   (i_start),
        .i_q       (i_q),
        .i_done    (i_done),
        .d_addr    (d_addr),
        .d_data    (d_data),
        .d_we      (d_we),
        .d_start   (d_start),
        .d_q       (d_q),
        .d_done    (d_done),
        .sdc_addr  (sdc_addr),
        .sdc_data  (sdc_data),
        .sdc_we    (sdc_we),
        .sdc_start (sdc_start),
        .sdc_q     (sdc_q),
        .sdc_done  (sdc_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit port, input logic [31:0] addr, input logic [31:0] data,
                                input bit we, input logic [31:0] rdata, input int lat);
        txn_t t;
        t.port = port; t.addr = addr; t.data = data; t.we = we; t.rdata = rdata; t.lat = lat;
        return t;
    endfunction

    // Controller model and done monitor share one process so queue peeks and pops stay ordered.
    initial begin : ctl_mon
        txn_t cur, t;
        int   cnt;
        bit   busy, wait_low;
        busy = 0; wait_low = 0; cnt = 0;
        cur = mk(0, 0, 0, 0, 0, 1);
        sdc_done = 1'b0;
        sdc_q = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mi = '0; md = '0;
                busy = 0; wait_low = 0;
                sdc_done = 1'b0;
            end else begin
                if (i_done || d_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {i_done, d_done}, 2'b00);
                    end else begin
                        t = exp_q.pop_front();
                        check("done_port", {d_done, i_done}, t.port ? 2'b10 : 2'b01);
                        check("read_q", t.port ? d_q : i_q, t.rdata);
                        if (t.port) begin md = t.rdata; d_cnt++; end
                        else begin mi = t.rdata; i_cnt++; end
                        $display("txn port=%s addr=%h we=%0d wdata=%h q=%h cyc=%0d",
                                 t.port ? "D" : "I", t.addr, t.we, t.data, t.port ? d_q : i_q, cyc);
                    end
                end
                check("i_q_hold", i_q, mi);
                check("d_q_hold", d_q, md);

                sdc_done = 1'b0;
                sdc_q = $urandom;
                if (wait_low) begin
                    check("sdc_start_drop", sdc_start, 1'b0);
                    wait_low = 0;
                end else if (busy) begin
                    check("sdc_start_level", sdc_start, 1'b1);
                    cnt--;
                    if (cnt == 0) begin
                        sdc_done = 1'b1;
                        sdc_q = cur.rdata;
                        busy = 0;
                        wait_low = 1;
                        done_cyc = cyc;
                    end
                end else if (sdc_start) begin
                    gap = cyc - done_cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", sdc_start, 1'b0);
                        cur = mk(0, 0, 0, 0, 32'h0, 3);
                    end else begin
                        cur = exp_q[0];
                        check("sdc_addr", sdc_addr, cur.addr);
                        check("sdc_data", sdc_data, cur.data);
                        check("sdc_we", sdc_we, cur.we);
                    end
                    cnt = cur.lat;
                    busy = 1;
                end else if (spur_req != spur_done) begin
                    sdc_done = 1'b1;
                    sdc_q = 32'h5555AAAA;
                    spur_done++;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_sdc_start"}, sdc_start, 1'b0);
        check({tag, "_sdc_addr"}, sdc_addr, 32'h0);
        check({tag, "_sdc_data"}, sdc_data, 32'h0);
        check({tag, "_sdc_we"}, sdc_we, 1'b0);
        check({tag, "_i_q"}, i_q, 32'h0);
        check({tag, "_d_q"}, d_q, 32'h0);
        check({tag, "_i_done"}, i_done, 1'b0);
        check({tag, "_d_done"}, d_done, 1'b0);
    endtask

    task automatic do_reset();
        i_start = 0; d_start = 0;
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input bit port);
        int   n;
        logic seen;
        n = 0; seen = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            seen = port ? d_done : i_done;
        end
        check(port ? "d_done_timeout" : "i_done_timeout", seen, 1'b1);
    endtask

    task automatic run_txn(input bit port, input logic [31:0] addr, input logic [31:0] data, input bit we);
        if (port) begin d_addr = addr; d_data = data; d_we = we; d_start = 1; end
        else begin i_addr = addr; i_data = data; i_we = we; i_start = 1; end
        wait_done(port);
        if (port) d_start = 0; else i_start = 0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int i0, d0, n;
        i_addr = 0; i_data = 0; i_we = 0; i_start = 0;
        d_addr = 0; d_data = 0; d_we = 0; d_start = 0;
        #1;
        do_reset();

        // Single I read, 5-cycle controller latency.
        exp_q.push_back(mk(0, 32'h000123, 32'h0, 0, 32'hDEADBEEF, 5));
        run_txn(0, 32'h000123, 32'h0, 0);

        // Simultaneous requests after reset: D first, I on the edge after D's done.
        do_reset();
        exp_q.push_back(mk(1, 32'h000010, 32'hCAFEF00D, 1, 32'h0, 4));
        exp_q.push_back(mk(0, 32'h000010, 32'h0, 0, 32'h13572468, 3));
        fork
            run_txn(1, 32'h000010, 32'hCAFEF00D, 1);
            run_txn(0, 32'h000010, 32'h0, 0);
        join
        check("gap_d_to_i", gap, 2);

        // D start held after done must not re-trigger until it drops.
        exp_q.push_back(mk(1, 32'h000020, 32'h0, 0, 32'hA1A2A3A4, 3));
        d_addr = 32'h000020; d_data = 0; d_we = 0; d_start = 1;
        wait_done(1);
        repeat (3) begin
            @(negedge clk);
            check("no_retrigger", sdc_start, 1'b0);
        end
        d_start = 0;
        @(negedge clk);
        exp_q.push_back(mk(1, 32'h000024, 32'h11223344, 1, 32'hB1B2B3B4, 3));
        run_txn(1, 32'h000024, 32'h11223344, 1);

        // Both ports re-requesting: strict I/D alternation, last grant was D.
        i0 = i_cnt; d0 = d_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(0, 32'h1000 + k, 32'h0, 0, 32'h10000000 + k, 3 + k));
            exp_q.push_back(mk(1, 32'h2000 + k, 32'h20000000 + k, (k % 2) == 1, 32'h30000000 + k, 4));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) run_txn(0, 32'h1000 + k, 32'h0, 0);
            end
            begin
                for (int k = 0; k < 4; k++) run_txn(1, 32'h2000 + k, 32'h20000000 + k, (k % 2) == 1);
            end
        join
        check("i_done_count", i_cnt - i0, 4);
        check("d_done_count", d_cnt - d0, 4);
        check("gap_alternate", gap, 2);

        // Spurious controller done while idle, then an I/O-range address.
        n = i_cnt + d_cnt;
        spur_req++;
        repeat (6) @(negedge clk);
        check("spurious_no_start", sdc_start, 1'b0);
        check("spurious_no_done", i_cnt + d_cnt, n);
        exp_q.push_back(mk(0, 32'h800004, 32'h0, 0, 32'h0BADF00D, 3));
        run_txn(0, 32'h800004, 32'h0, 0);

        // Reset in the middle of a D transaction.
        exp_q.push_back(mk(1, 32'h000300, 32'h0, 0, 32'hFEEDFACE, 20));
        d_addr = 32'h000300; d_data = 0; d_we = 0; d_start = 1;
        n = 0;
        while (!sdc_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("busy_d_reached", sdc_start, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_no_req", sdc_start, 1'b0);
        end
        d_start = 0;
        @(negedge clk);
        exp_q.push_back(mk(1, 32'h000304, 32'h0, 0, 32'h0F0F0F0F, 3));
        run_txn(1, 32'h000304, 32'h0, 0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
